// File: rtl/sk9822_frame_scheduler.sv
// Double-buffered SK9822 frame store with an iomem register window and a
// refresh scheduler that swaps front/back banks only when a frame starts.
module sk9822_frame_scheduler #(
  parameter logic [15:0] ADDR = 16'h4000,
  parameter int          LEDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        drv_start,
  input  logic        drv_busy,
  input  logic        drv_re,
  input  logic [3:0]  drv_raddr,
  output logic [23:0] drv_rdata,
  output logic        frame_irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_START,
    S_ACK,
    S_RUN
  } state_t;

  localparam logic [5:0] OFF_CTRL   = 6'h10;
  localparam logic [5:0] OFF_PERIOD = 6'h11;
  localparam logic [5:0] OFF_STATUS = 6'h12;

  state_t      state_q, state_d;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic        fs_q, fs_d;
  logic        pending_q, pending_d;
  logic        enable_q, enable_d;
  logic        overrun_q, overrun_d;
  logic [23:0] period_q, period_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] cnt_dec;
  logic [15:0] fcount_q, fcount_d;
  logic        irq_q, irq_d;
  logic [23:0] drv_rdata_q;

  logic [23:0] bank0_w [LEDS];
  logic [23:0] bank1_w [LEDS];

  logic       sel;
  logic       wr;
  logic [5:0] word_off;
  logic       pix_hit;
  logic [3:0] pix_idx;
  logic       is_start;
  logic       in_frame;
  logic       unused_bits;

  assign sel      = iomem_valid && !ready_q && (iomem_addr[31:16] == ADDR);
  assign wr       = sel && (|iomem_wstrb);
  assign word_off = iomem_addr[7:2];
  assign pix_hit  = word_off < 6'(LEDS);
  assign pix_idx  = word_off[3:0];
  assign is_start = (state_q == S_START);
  assign in_frame = (state_q == S_ACK) || (state_q == S_RUN);
  assign cnt_dec  = (cnt_q != 24'd0) ? cnt_q - 24'd1 : 24'd0;

  assign unused_bits = ^{iomem_addr[15:8], iomem_addr[1:0], iomem_wdata[31:24]};

  // Per-pixel storage; writes always land in the bank that is currently back.
  for (genvar gi = 0; gi < LEDS; gi++) begin : g_pix
    logic [23:0] b0_q;
    logic [23:0] b1_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        b0_q <= '0;
        b1_q <= '0;
      end else if (wr && pix_hit && (pix_idx == 4'(gi))) begin
        if (fs_q) begin
          b0_q <= iomem_wdata[23:0];
        end else begin
          b1_q <= iomem_wdata[23:0];
        end
      end
    end

    assign bank0_w[gi] = b0_q;
    assign bank1_w[gi] = b1_q;
  end

  always_comb begin
    rdata_d = '0;
    if (sel) begin
      case (word_off)
        OFF_CTRL:   rdata_d = {30'd0, pending_q, enable_q};
        OFF_PERIOD: rdata_d = {8'd0, period_q};
        OFF_STATUS: rdata_d = {fcount_q, 12'd0, overrun_q, drv_busy, pending_q, fs_q};
        default: begin
          if (pix_hit) begin
            rdata_d = {8'd0, fs_q ? bank0_w[pix_idx] : bank1_w[pix_idx]};
          end
        end
      endcase
    end
  end

  // The swap consumes the old pending flag first so a coincident commit write re-arms it.
  always_comb begin
    enable_d  = enable_q;
    period_d  = period_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    fs_d      = fs_q;
    if (is_start && pending_q) begin
      fs_d      = !fs_q;
      pending_d = 1'b0;
    end
    if (wr) begin
      case (word_off)
        OFF_CTRL: begin
          enable_d = iomem_wdata[0];
          if (iomem_wdata[1]) begin
            pending_d = 1'b1;
          end
        end
        OFF_PERIOD: period_d = iomem_wdata[23:0];
        OFF_STATUS: begin
          if (iomem_wdata[3]) begin
            overrun_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
    // A start falls due once the counter is about to expire; still mid-frame means it is late.
    if (in_frame && (cnt_dec == 24'd0)) begin
      overrun_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_dec;
    fcount_d = fcount_q;
    irq_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable_q) begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!enable_q) begin
          state_d = S_IDLE;
        end else if ((cnt_dec == 24'd0) && !drv_busy) begin
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = (period_q < 24'd2) ? 24'd0 : period_q - 24'd1;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (drv_busy) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!drv_busy) begin
          irq_d    = 1'b1;
          fcount_d = fcount_q + 16'd1;
          state_d  = enable_q ? S_COUNT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      fs_q        <= 1'b0;
      pending_q   <= 1'b0;
      enable_q    <= 1'b0;
      overrun_q   <= 1'b0;
      period_q    <= '0;
      cnt_q       <= '0;
      fcount_q    <= '0;
      irq_q       <= 1'b0;
      drv_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= sel;
      rdata_q   <= rdata_d;
      fs_q      <= fs_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      overrun_q <= overrun_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      fcount_q  <= fcount_d;
      irq_q     <= irq_d;
      if (drv_re) begin
        drv_rdata_q <= ({1'b0, drv_raddr} < 5'(LEDS))
                       ? (fs_q ? bank1_w[drv_raddr] : bank0_w[drv_raddr]) : '0;
      end
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign drv_start   = is_start;
  assign frame_irq   = irq_q;
  assign drv_rdata   = drv_rdata_q;

endmodule

// File: tb/tb_sk9822_frame_scheduler.sv
// Bench for sk9822_frame_scheduler: register table, refresh timing, commit/swap,
// overrun, disable-in-frame and reset-in-frame sequences against a busy-driver model.
module tb_sk9822_frame_scheduler;

  localparam logic [15:0] ADDR = 16'h4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        drv_start;
  logic        drv_busy;
  logic        drv_re;
  logic [3:0]  drv_raddr;
  logic [23:0] drv_rdata;
  logic        frame_irq;

  sk9822_frame_scheduler #(.ADDR(ADDR), .LEDS(16)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .drv_start(drv_start), .drv_busy(drv_busy), .drv_re(drv_re), .drv_raddr(drv_raddr),
    .drv_rdata(drv_rdata), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_len = 40;
  int bcnt;
  int start_total, irq_total;
  bit prev_busy;
  int irq_q[$];
  int fall_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Serialiser model: busy for busy_len cycles starting the cycle after drv_start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      drv_busy <= 1'b0;
      bcnt     <= 0;
    end else if (drv_start) begin
      drv_busy <= 1'b1;
      bcnt     <= busy_len;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      drv_busy <= 1'b0;
      bcnt     <= 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      start_total = 0;
      irq_total   = 0;
      prev_busy   = 1'b0;
    end else begin
      if (drv_start) start_total++;
      if (frame_irq) begin
        irq_total++;
        irq_q.push_back(cyc);
      end
      if (prev_busy && !drv_busy) fall_q.push_back(cyc);
      prev_busy = drv_busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one access and returns at the negedge after ready.
  task automatic bus_op(input bit we, input logic [7:0] off, input logic [31:0] wd,
                        output logic [31:0] rd);
    int n;
    iomem_valid = 1'b1;
    iomem_wstrb = we ? 4'hF : 4'h0;
    iomem_addr  = {ADDR, 8'h00, off};
    iomem_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 8);
    check("ready_seen", iomem_ready, 1);
    rd = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    check("ready_1cyc", iomem_ready, 0);
    check("rdata_idle", iomem_rdata, 0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd);
    logic [31:0] d;
    @(negedge clk);
    bus_op(1'b1, off, wd, d);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] mask,
                        input logic [31:0] exp);
    logic [31:0] d;
    exp_q.push_back(exp);
    @(negedge clk);
    bus_op(1'b0, off, 32'h0, d);
    check(name, d & mask, exp_q.pop_front());
  endtask

  task automatic drv_read(input logic [3:0] idx, output logic [23:0] d);
    @(negedge clk);
    drv_re    = 1'b1;
    drv_raddr = idx;
    @(negedge clk);
    d      = drv_rdata;
    drv_re = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (drv_start) begin
        at = cyc;
        break;
      end
    end
    check("start_seen", (at >= 0), 1);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 200 && cyc != target; i++) @(negedge clk);
    check("cycle_reach", (cyc == target), 1);
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d;
    logic [23:0] px;
    logic        ready_any;
    int s, s0, s1, s2, t0, t1, t2, r, snap_start, snap_irq;

    tbl[0]  = '{1'b0, 8'h48, 32'h0,         32'h00000000};
    tbl[1]  = '{1'b1, 8'h0C, 32'hAAFF8040,  32'h0};
    tbl[2]  = '{1'b0, 8'h0C, 32'h0,         32'h00FF8040};
    tbl[3]  = '{1'b0, 8'h40, 32'h0,         32'h00000000};
    tbl[4]  = '{1'b1, 8'h44, 32'hFF000064,  32'h0};
    tbl[5]  = '{1'b0, 8'h44, 32'h0,         32'h00000064};
    tbl[6]  = '{1'b1, 8'h4C, 32'hFFFFFFFF,  32'h0};
    tbl[7]  = '{1'b0, 8'h4C, 32'h0,         32'h00000000};
    tbl[8]  = '{1'b0, 8'h3C, 32'h0,         32'h00000000};
    tbl[9]  = '{1'b1, 8'h3C, 32'h00ABCDEF,  32'h0};
    tbl[10] = '{1'b0, 8'h3C, 32'h0,         32'h00ABCDEF};
    tbl[11] = '{1'b1, 8'h48, 32'h00000007,  32'h0};
    tbl[12] = '{1'b0, 8'h48, 32'h0,         32'h00000000};
    tbl[13] = '{1'b0, 8'h0C, 32'h0,         32'h00FF8040};

    reset = 1'b1;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = '0; iomem_wdata = '0;
    drv_re = 1'b0; drv_raddr = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", iomem_ready, 0);
    check("rst_rdata", iomem_rdata, 0);
    check("rst_start", drv_start, 0);
    check("rst_irq", frame_irq, 0);
    check("rst_drv_rdata", drv_rdata, 0);
    reset = 1'b0;

    // Register table with scoreboarded read data.
    foreach (tbl[i]) begin
      if (!tbl[i].we) exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      bus_op(tbl[i].we, tbl[i].off, tbl[i].data, d);
      if (!tbl[i].we) check($sformatf("tbl%0d", i), d, exp_q.pop_front());
      $display("txn %0d %s off=0x%02h data=0x%08h", i, tbl[i].we ? "WR" : "RD",
               tbl[i].off, tbl[i].we ? tbl[i].data : d);
    end

    // Foreign address must not be acknowledged or written.
    @(negedge clk);
    iomem_valid = 1'b1; iomem_wstrb = 4'hF; iomem_addr = 32'h3000_000C; iomem_wdata = 32'h111111;
    ready_any = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ready_any = ready_any | iomem_ready;
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    check("foreign_ready", ready_any, 0);
    rd_chk("foreign_nowrite", 8'h0C, 32'hFFFFFFFF, 32'h00FF8040);
    drv_read(4'd3, px);
    check("front_px3_untouched", px, 0);

    // Regular refresh: PERIOD=100, 40-cycle frames.
    busy_len = 40;
    wr(8'h40, 32'h1);
    irq_q.delete(); fall_q.delete();
    wait_start(10, s0);
    wait_start(150, s1);
    wait_start(150, s2);
    check("period_1", s1 - s0, 100);
    check("period_2", s2 - s1, 100);
    check("irq_count", (irq_q.size() >= 2 && fall_q.size() >= 2), 1);
    if (irq_q.size() >= 2 && fall_q.size() >= 2) begin
      check("irq_after_fall0", irq_q[0], fall_q[0] + 1);
      check("irq_after_fall1", irq_q[1], fall_q[1] + 1);
    end
    rd_chk("no_overrun", 8'h48, 32'h8, 32'h0);

    // Commit a new pixel 0 and observe the swap at the next start.
    wr(8'h00, 32'h00123456);
    wr(8'h40, 32'h3);
    rd_chk("pending_set", 8'h48, 32'h2, 32'h2);
    wait_start(150, s);
    rd_chk("swapped", 8'h48, 32'h3, 32'h1);
    drv_read(4'd0, px);
    check("front_px0", px, 24'h123456);
    drv_read(4'd3, px);
    check("front_px3", px, 24'hFF8040);
    rd_chk("back_px0_old", 8'h00, 32'hFFFFFFFF, 32'h0);
    rd_chk("back_px3_old", 8'h0C, 32'hFFFFFFFF, 32'h0);

    // Overrun: PERIOD=10 with 30-cycle frames.
    wr(8'h44, 32'd10);
    busy_len = 30;
    wait_start(200, s);
    wait_start(200, t0);
    irq_q.delete();
    wait_start(200, t1);
    wait_start(200, t2);
    check("ovr_spacing", (t1 - t0 >= 32 && t1 - t0 <= 33), 1);
    check("ovr_irqs", (irq_q.size() >= 2), 1);
    if (irq_q.size() >= 2) begin
      check("start1_after_irq", (t1 - irq_q[0] >= 1 && t1 - irq_q[0] <= 2), 1);
      check("start2_after_irq", (t2 - irq_q[1] >= 1 && t2 - irq_q[1] <= 2), 1);
    end
    rd_chk("overrun_set", 8'h48, 32'h8, 32'h8);
    wr(8'h40, 32'h0);
    repeat (60) @(negedge clk);
    rd_chk("overrun_sticky", 8'h48, 32'h8, 32'h8);
    wr(8'h48, 32'h8);
    rd_chk("overrun_clear", 8'h48, 32'hF, 32'h1);

    // Commit write landing in the START cycle.
    wr(8'h44, 32'd20);
    busy_len = 5;
    wr(8'h40, 32'h1);
    wait_start(10, s);
    wr(8'h40, 32'h3);
    wait_cyc(s + 20);
    check("start_align", drv_start, 1);
    bus_op(1'b1, 8'h40, 32'h3, d);
    rd_chk("coincident_commit", 8'h48, 32'hB, 32'h2);

    // Disable during RUN: frame finishes with an irq, then nothing more.
    wait_start(40, s);
    wait_cyc(s + 2);
    snap_start = start_total;
    snap_irq   = irq_total;
    bus_op(1'b1, 8'h40, 32'h0, d);
    repeat (60) @(negedge clk);
    check("disable_irq", irq_total, snap_irq + 1);
    check("disable_nostart", start_total, snap_start);
    rd_chk("frame_count", 8'h48, 32'hFFFF0000, 32'(irq_total) << 16);
    rd_chk("after_disable_fs", 8'h48, 32'hB, 32'h1);

    // Reset in the middle of a frame.
    drv_read(4'd0, px);
    check("pre_reset_drv_rdata", px, 24'h123456);
    wr(8'h40, 32'h1);
    wait_start(10, s);
    repeat (3) @(negedge clk);
    check("in_run", drv_busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_start", drv_start, 0);
    check("mid_rst_irq", frame_irq, 0);
    check("mid_rst_ready", iomem_ready, 0);
    check("mid_rst_drv_rdata", drv_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("post_rst_status", 8'h48, 32'hFFFFFFFF, 32'h0);
    rd_chk("post_rst_ctrl", 8'h40, 32'hFFFFFFFF, 32'h0);
    rd_chk("post_rst_period", 8'h44, 32'hFFFFFFFF, 32'h0);
    rd_chk("post_rst_px0", 8'h00, 32'hFFFFFFFF, 32'h0);
    repeat (30) @(negedge clk);
    check("post_rst_quiet", start_total + irq_total, 0);
    @(negedge clk);
    bus_op(1'b1, 8'h40, 32'h1, d);
    r = cyc - 1;
    wait_start(5, s);
    check("reenable_latency", (s >= 0 && s - r <= 2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
